mux4_rr_arbiter: RTL and testbench



---
 rtl/mux_ctrl_pkg.sv | 44 ++++
 rtl/mux4_1.sv | 12 +
 rtl/mux4_rr_arbiter.sv | 109 ++++++++++
 tb/tb_mux4_rr_arbiter.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/mux_ctrl_pkg.sv
// Shared types and helpers for the round-robin mux arbiter: state enum,
// requester count, select width, one-hot decode and the rotating pick.
package mux_ctrl_pkg;

  localparam int NUM_REQ = 4;
  localparam int SEL_W   = 2;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  typedef struct packed {
    logic             found;
    logic [SEL_W-1:0] idx;
  } pick_t;

  function automatic logic [NUM_REQ-1:0] onehot_dec(input logic [SEL_W-1:0] sel);
    logic [NUM_REQ-1:0] oh;
    oh      = '0;
    oh[sel] = 1'b1;
    return oh;
  endfunction

  // Scans ptr, ptr+1, ... (wrapping); the loop runs backwards so the
  // closest candidate to ptr is the last one written and therefore wins.
  function automatic pick_t rr_pick(input logic [NUM_REQ-1:0] req,
                                    input logic [SEL_W-1:0]   ptr,
                                    input logic               excl_en,
                                    input logic [SEL_W-1:0]   excl_idx);
    pick_t            res;
    logic [SEL_W-1:0] idx;
    res = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = ptr + SEL_W'(k);
      if (req[idx] && !(excl_en && (idx == excl_idx))) begin
        res.found = 1'b1;
        res.idx   = idx;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/mux4_1.sv
// Plain 4:1 single-bit multiplexer shared by the arbitrated requesters.
module mux4_1
  import mux_ctrl_pkg::*;
(
  input  logic [NUM_REQ-1:0] a_in,
  input  logic [SEL_W-1:0]   sel_in,
  output logic               y_out
);

  assign y_out = a_in[sel_in];

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin owner arbitration in front of mux4_1 with a hold timer that
// forces a handoff once an owner has kept the grant MAX_HOLD cycles.
module mux4_rr_arbiter
  import mux_ctrl_pkg::*;
#(
  parameter int MAX_HOLD = 8
) (
  input  logic                clk_in,
  input  logic                rst_n_in,
  input  logic [NUM_REQ-1:0]  req_in,
  input  logic [NUM_REQ-1:0]  a_in,
  output logic [NUM_REQ-1:0]  gnt_out,
  output logic [SEL_W-1:0]    sel_out,
  output logic                busy_out,
  output logic                y_out
);

  localparam int                CNT_W     = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [CNT_W-1:0]  HOLD_LAST = CNT_W'(MAX_HOLD - 1);

  state_e             state_q, state_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic [SEL_W-1:0]   ptr_q, ptr_d;
  logic [CNT_W-1:0]   hold_q, hold_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic               busy_q, busy_d;

  pick_t              pick_any;
  pick_t              pick_oth;
  logic               grant_now;
  logic [SEL_W-1:0]   new_idx;

  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    ptr_d     = ptr_q;
    hold_d    = hold_q;
    grant_now = 1'b0;
    new_idx   = sel_q;
    pick_any  = rr_pick(req_in, ptr_q, 1'b0, sel_q);
    pick_oth  = rr_pick(req_in, ptr_q, 1'b1, sel_q);

    case (state_q)
      IDLE: begin
        if (pick_any.found) begin
          grant_now = 1'b1;
          new_idx   = pick_any.idx;
        end
      end
      BUSY: begin
        if (!req_in[sel_q]) begin
          if (pick_oth.found) begin
            grant_now = 1'b1;
            new_idx   = pick_oth.idx;
          end else begin
            state_d = IDLE;
          end
        end else if ((hold_q == HOLD_LAST) && pick_oth.found) begin
          grant_now = 1'b1;
          new_idx   = pick_oth.idx;
        end else if (hold_q != HOLD_LAST) begin
          hold_d = hold_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // Any new owner, from idle or by handoff, restarts the timer and
    // moves priority just past itself.
    if (grant_now) begin
      state_d = BUSY;
      sel_d   = new_idx;
      ptr_d   = new_idx + SEL_W'(1);
      hold_d  = '0;
    end

    busy_d = (state_d == BUSY);
    gnt_d  = busy_d ? onehot_dec(sel_d) : '0;
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q <= IDLE;
      sel_q   <= '0;
      ptr_q   <= '0;
      hold_q  <= '0;
      gnt_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
      hold_q  <= hold_d;
      gnt_q   <= gnt_d;
      busy_q  <= busy_d;
    end
  end

  assign gnt_out  = gnt_q;
  assign sel_out  = sel_q;
  assign busy_out = busy_q;

  mux4_1 u_mux (
    .a_in   (a_in),
    .sel_in (sel_q),
    .y_out  (y_out)
  );

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Bench for mux4_rr_arbiter: two instances (MAX_HOLD 8 and 2) share stimulus
// and are compared every cycle against an ownership-level reference model.
module tb_mux4_rr_arbiter;

  logic       clk_in;
  logic       rst_n_in;
  logic [3:0] req_in;
  logic [3:0] a_in;

  logic [3:0] gnt8, gnt2;
  logic [1:0] sel8, sel2;
  logic       busy8, busy2, y8, y2;

  int errors = 0;
  int checks = 0;
  logic cmp_en = 1'b0;

  mux4_rr_arbiter #(.MAX_HOLD(8)) u_dut8 (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .req_in(req_in), .a_in(a_in),
    .gnt_out(gnt8), .sel_out(sel8), .busy_out(busy8), .y_out(y8)
  );

  mux4_rr_arbiter #(.MAX_HOLD(2)) u_dut2 (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .req_in(req_in), .a_in(a_in),
    .gnt_out(gnt2), .sel_out(sel2), .busy_out(busy2), .y_out(y2)
  );

  // clock / reset
  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  // ---------------- reference model ----------------
  int         mh[2] = '{8, 2};
  int         m_busy[2] = '{0, 0};
  int         m_own[2]  = '{0, 0};
  int         m_ptr[2]  = '{0, 0};
  int         m_held[2] = '{0, 0};
  int         m_wait[2][4];
  logic [3:0] req_smp = '0;

  function automatic int pick(input logic [3:0] r, input int p, input int excl);
    for (int k = 0; k < 4; k++) begin
      int i;
      i = (p + k) % 4;
      if (r[i] && i != excl) return i;
    end
    return -1;
  endfunction

  task automatic model_grant(input int d, input int w);
    m_busy[d] = 1;
    m_own[d]  = w;
    m_ptr[d]  = (w + 1) % 4;
    m_held[d] = 1;
  endtask

  task automatic model_step(input int d);
    int w;
    if (m_busy[d] == 0) begin
      w = pick(req_smp, m_ptr[d], -1);
      if (w >= 0) model_grant(d, w);
    end else begin
      w = pick(req_smp, m_ptr[d], m_own[d]);
      if (!req_smp[m_own[d]]) begin
        if (w >= 0) model_grant(d, w);
        else m_busy[d] = 0;
      end else if (m_held[d] >= mh[d] && w >= 0) begin
        model_grant(d, w);
      end else if (m_held[d] < 1000) begin
        m_held[d]++;
      end
    end
    for (int i = 0; i < 4; i++) begin
      if (req_smp[i] && !(m_busy[d] != 0 && m_own[d] == i)) m_wait[d][i]++;
      else m_wait[d][i] = 0;
    end
  endtask

  always @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      req_smp = '0;
      for (int d = 0; d < 2; d++) begin
        m_busy[d] = 0; m_own[d] = 0; m_ptr[d] = 0; m_held[d] = 0;
        for (int i = 0; i < 4; i++) m_wait[d][i] = 0;
      end
    end else begin
      req_smp = req_in;
      model_step(0);
      model_step(1);
    end
  end

  // ---------------- scoreboard ----------------
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk_in) begin
    if (cmp_en) begin
      for (int d = 0; d < 2; d++) begin
        logic [3:0] g, eg;
        logic [1:0] s;
        logic       b, y;
        int         lim;
        g = (d == 0) ? gnt8 : gnt2;
        s = (d == 0) ? sel8 : sel2;
        b = (d == 0) ? busy8 : busy2;
        y = (d == 0) ? y8 : y2;
        eg = (m_busy[d] != 0) ? 4'(1 << m_own[d]) : 4'b0000;
        chk($sformatf("gnt[%0d]", d), 32'(g), 32'(eg));
        chk($sformatf("sel[%0d]", d), 32'(s), 32'(m_own[d]));
        chk($sformatf("busy[%0d]", d), 32'(b), 32'(m_busy[d] != 0));
        chk($sformatf("y[%0d]", d), 32'(y), 32'((a_in >> m_own[d]) & 4'b0001));
        chk($sformatf("onehot0[%0d]", d), 32'($onehot0(g)), 32'd1);
        chk($sformatf("gnt_no_req[%0d]", d), 32'(g & ~req_smp), 32'd0);
        lim = 3 * mh[d] + 3;
        for (int i = 0; i < 4; i++)
          chk($sformatf("wait_ok[%0d][%0d]", d, i), 32'(m_wait[d][i] <= lim), 32'd1);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step_cyc();
    @(negedge clk_in);
    #1;
  endtask

  task automatic do_reset();
    rst_n_in = 1'b0;
    req_in   = '0;
    step_cyc();
    rst_n_in = 1'b1;
  endtask

  logic [3:0] rr_exp[9];

  initial begin
    rst_n_in = 1'b0;
    req_in   = '0;
    a_in     = '0;
    rr_exp   = '{4'b0001, 4'b0001, 4'b0010, 4'b0010, 4'b0100,
                 4'b0100, 4'b1000, 4'b1000, 4'b0001};
    #12;
    chk("rst_gnt", 32'(gnt8), 32'd0);
    chk("rst_sel", 32'(sel8), 32'd0);
    chk("rst_busy", 32'(busy8), 32'd0);
    step_cyc();
    rst_n_in = 1'b1;
    cmp_en   = 1'b1;

    // single request
    req_in = 4'b0100;
    a_in   = 4'b0100;
    step_cyc();
    chk("single_gnt", 32'(gnt8), 32'b0100);
    chk("single_sel", 32'(sel8), 32'd2);
    chk("single_y", 32'(y8), 32'd1);
    req_in = 4'b0000;
    step_cyc();
    chk("release_gnt", 32'(gnt8), 32'd0);
    chk("release_sel_hold", 32'(sel8), 32'd2);

    // asynchronous reset while granted
    req_in = 4'b0010;
    step_cyc();
    chk("pre_rst_gnt", 32'(gnt8), 32'b0010);
    #2;
    rst_n_in = 1'b0;
    #1;
    chk("async_rst_gnt", 32'(gnt8), 32'd0);
    chk("async_rst_sel", 32'(sel8), 32'd0);
    chk("async_rst_busy", 32'(busy8), 32'd0);
    chk("async_rst_gnt2", 32'(gnt2), 32'd0);

    // round robin with MAX_HOLD = 2
    req_in = 4'b1111;
    step_cyc();
    rst_n_in = 1'b1;
    for (int k = 0; k < 9; k++) begin
      step_cyc();
      chk($sformatf("rr_seq[%0d]", k), 32'(gnt2), 32'(rr_exp[k]));
    end

    // zero-gap handoff 1 -> 3
    do_reset();
    req_in = 4'b0010;
    step_cyc();
    chk("hand_own1", 32'(gnt8), 32'b0010);
    req_in = 4'b1010;
    step_cyc();
    chk("hand_keep1", 32'(gnt8), 32'b0010);
    req_in = 4'b1000;
    step_cyc();
    chk("hand_to3", 32'(gnt8), 32'b1000);
    chk("hand_busy", 32'(busy8), 32'd1);

    // preemption after saturation
    do_reset();
    req_in = 4'b0001;
    repeat (20) step_cyc();
    chk("sat_own0", 32'(gnt8), 32'b0001);
    req_in = 4'b0101;
    step_cyc();
    chk("preempt_to2", 32'(gnt8), 32'b0100);

    // randomized traffic
    do_reset();
    for (int n = 0; n < 10000; n++) begin
      logic [3:0] r;
      r = req_in;
      for (int i = 0; i < 4; i++)
        if ($urandom_range(0, 7) == 0) r[i] = ~r[i];
      req_in = r;
      a_in   = 4'($urandom);
      step_cyc();
    end
    req_in = '0;
    step_cyc();
    step_cyc();
    cmp_en = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
